// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the full_adder block.
package full_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

    // Two's-complement overflow from the carries into and out of the MSB.
    function automatic logic signed_ovf(input logic c_msb, input logic c_prev);
        return c_msb ^ c_prev;
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Bundle of the full_adder data and result signals for benches and integrators.
interface full_adder_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  sum, cout, sum_q, cout_q, ovf_q, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, cout, sum_q, cout_q, ovf_q, out_valid
    );
endinterface

// File: rtl/full_adder_bit.sv
// Single-bit full-adder cell.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with an immediate result and a one-cycle registered copy.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);
    logic [WIDTH:0]   carry;
    logic             ovf_c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             out_valid_d;
    logic             out_valid_q;

    assign carry[0] = cin;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout  = carry[WIDTH];
    assign ovf_c = signed_ovf(carry[WIDTH], carry[WIDTH-1]);

    // Capture on in_valid; otherwise hold the result and drop out_valid.
    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum;
            cout_d      = cout;
            ovf_d       = ovf_c;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 8 and 4.
module tb_full_adder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if8 ();
    full_adder_if #(.WIDTH(4)) if4 ();

    full_adder #(.WIDTH(1)) u_w1 (
        .sum(if1.sum), .cout(if1.cout), .a(if1.a), .b(if1.b), .cin(if1.cin),
        .clk(clk), .rst_n(rst_n), .in_valid(if1.in_valid),
        .sum_q(if1.sum_q), .cout_q(if1.cout_q), .ovf_q(if1.ovf_q), .out_valid(if1.out_valid)
    );
    full_adder #(.WIDTH(8)) u_w8 (
        .sum(if8.sum), .cout(if8.cout), .a(if8.a), .b(if8.b), .cin(if8.cin),
        .clk(clk), .rst_n(rst_n), .in_valid(if8.in_valid),
        .sum_q(if8.sum_q), .cout_q(if8.cout_q), .ovf_q(if8.ovf_q), .out_valid(if8.out_valid)
    );
    full_adder #(.WIDTH(4)) u_w4 (
        .sum(if4.sum), .cout(if4.cout), .a(if4.a), .b(if4.b), .cin(if4.cin),
        .clk(clk), .rst_n(rst_n), .in_valid(if4.in_valid),
        .sum_q(if4.sum_q), .cout_q(if4.cout_q), .ovf_q(if4.ovf_q), .out_valid(if4.out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Signed overflow: operands read as two's complement, cin added as +1.
    function automatic logic ref_ovf(input int w, input int a, input int b, input int c);
        int sa, sb, r, lim;
        lim = 1 << (w - 1);
        sa  = (a >= lim) ? a - (1 << w) : a;
        sb  = (b >= lim) ? b - (1 << w) : b;
        r   = sa + sb + c;
        return (r > lim - 1) || (r < -lim);
    endfunction

    initial begin
        logic [7:0] exp_s1;
        logic [7:0] exp_c1;
        int         tot;
        logic [3:0] m_sum;
        logic       m_cout, m_ovf, m_valid;

        n_checks = 0;
        n_fail   = 0;
        exp_s1   = 8'b1001_0110;
        exp_c1   = 8'b1110_1000;
        rst_n    = 1'b0;
        {if1.a, if1.b, if1.cin, if1.in_valid} = '0;
        {if8.a, if8.b, if8.cin, if8.in_valid} = '0;
        {if4.a, if4.b, if4.cin, if4.in_valid} = '0;

        #1;
        check("rst_sum_q", 32'(if8.sum_q), 32'h0);
        check("rst_cout_q", 32'(if8.cout_q), 32'h0);
        check("rst_ovf_q", 32'(if8.ovf_q), 32'h0);
        check("rst_out_valid", 32'(if8.out_valid), 32'h0);
        check("rst_w4_valid", 32'(if4.out_valid), 32'h0);

        // Exhaustive 1-bit truth table, combinational path works under reset.
        for (int i = 0; i < 8; i++) begin
            {if1.a, if1.b, if1.cin} = 3'(i);
            #10;
            check($sformatf("w1_sum_%0d", i), 32'(if1.sum), 32'(exp_s1[i]));
            check($sformatf("w1_cout_%0d", i), 32'(if1.cout), 32'(exp_c1[i]));
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Wrap-around of all-ones plus carry in.
        if8.a = 8'hFF; if8.b = 8'h00; if8.cin = 1'b1; if8.in_valid = 1'b1;
        #1;
        check("w8_wrap_sum", 32'(if8.sum), 32'h00);
        check("w8_wrap_cout", 32'(if8.cout), 32'h1);
        @(negedge clk);
        check("w8_wrap_sum_q", 32'(if8.sum_q), 32'h00);
        check("w8_wrap_cout_q", 32'(if8.cout_q), 32'h1);
        check("w8_wrap_ovf_q", 32'(if8.ovf_q), 32'h0);
        check("w8_wrap_valid", 32'(if8.out_valid), 32'h1);

        // Positive overflow into the sign bit.
        if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0;
        #1;
        check("w8_ovf_sum", 32'(if8.sum), 32'h80);
        check("w8_ovf_cout", 32'(if8.cout), 32'h0);
        @(negedge clk);
        check("w8_ovf_sum_q", 32'(if8.sum_q), 32'h80);
        check("w8_ovf_ovf_q", 32'(if8.ovf_q), 32'h1);

        if8.a = 8'd100; if8.b = 8'd27; if8.cin = 1'b1;
        @(negedge clk);
        check("w8_128_sum_q", 32'(if8.sum_q), 32'd128);
        check("w8_128_cout_q", 32'(if8.cout_q), 32'h0);
        check("w8_128_valid", 32'(if8.out_valid), 32'h1);
        if8.in_valid = 1'b0;
        @(negedge clk);
        check("w8_hold_valid", 32'(if8.out_valid), 32'h0);
        check("w8_hold_sum_q", 32'(if8.sum_q), 32'd128);

        // Reset between edges clears the register stage, not the comb path.
        if8.a = 8'h55; if8.b = 8'h22; if8.cin = 1'b0; if8.in_valid = 1'b1;
        @(negedge clk);
        check("w8_pre_rst_sum_q", 32'(if8.sum_q), 32'h77);
        check("w8_pre_rst_valid", 32'(if8.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum_q", 32'(if8.sum_q), 32'h0);
        check("mid_rst_cout_q", 32'(if8.cout_q), 32'h0);
        check("mid_rst_ovf_q", 32'(if8.ovf_q), 32'h0);
        check("mid_rst_valid", 32'(if8.out_valid), 32'h0);
        if8.a = 8'hF0; if8.b = 8'h20; if8.cin = 1'b1;
        #1;
        check("mid_rst_comb_sum", 32'(if8.sum), 32'h11);
        check("mid_rst_comb_cout", 32'(if8.cout), 32'h1);
        @(negedge clk);
        check("in_rst_valid", 32'(if8.out_valid), 32'h0);
        rst_n = 1'b1;
        if8.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(if8.out_valid), 32'h0);
        check("post_rst_sum_q", 32'(if8.sum_q), 32'h0);

        // Randomized 4-bit run against an arithmetic model of both paths.
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            check("w4_sum_q", 32'(if4.sum_q), 32'(m_sum));
            check("w4_cout_q", 32'(if4.cout_q), 32'(m_cout));
            check("w4_ovf_q", 32'(if4.ovf_q), 32'(m_ovf));
            check("w4_valid", 32'(if4.out_valid), 32'(m_valid));
            if4.a        = 4'($urandom_range(0, 15));
            if4.b        = 4'($urandom_range(0, 15));
            if4.cin      = 1'($urandom_range(0, 1));
            if4.in_valid = 1'($urandom_range(0, 1));
            tot = int'(if4.a) + int'(if4.b) + int'(if4.cin);
            #1;
            check("w4_sum", 32'(if4.sum), 32'(tot % 16));
            check("w4_cout", 32'(if4.cout), 32'(tot / 16));
            m_valid = if4.in_valid;
            if (if4.in_valid) begin
                m_sum  = 4'(tot % 16);
                m_cout = 1'(tot / 16);
                m_ovf  = ref_ovf(4, int'(if4.a), int'(if4.b), int'(if4.cin));
            end
            @(negedge clk);
        end
        check("w4_final_sum_q", 32'(if4.sum_q), 32'(m_sum));
        check("w4_final_valid", 32'(if4.out_valid), 32'(m_valid));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
